// File: rtl/keypad_pkg.sv
// Shared keypad definitions: FSM states, key map and column drive codes.
// Used by the entry block and by any other keypad consumer.
package keypad_pkg;

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;

    // Nibble {row, col} holds the legend printed on that key.
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    localparam logic [3:0] COL0 = 4'b1110;
    localparam logic [3:0] COL1 = 4'b1101;
    localparam logic [3:0] COL2 = 4'b1011;
    localparam logic [3:0] COL3 = 4'b0111;

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] c;
        unique case (idx)
            2'd0: c = COL0;
            2'd1: c = COL1;
            2'd2: c = COL2;
            default: c = COL3;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] key_lookup(
        input logic [1:0] r,
        input logic [1:0] c
    );
        logic [5:0] base;
        base = {r, c, 2'b00};
        return KEY_MAP[base +: 4];
    endfunction

endpackage

// File: rtl/keypad_decode.sv
// Maps the active column and a row pattern to a key code.
// Patterns without exactly one low row are reported as no key.
module keypad_decode (
    input  logic [1:0] col_idx,
    input  logic [3:0] row_pat,
    output logic       valid,
    output logic [3:0] code
);
    import keypad_pkg::*;

    logic [1:0] r;

    always_comb begin
        valid = 1'b1;
        r     = 2'd0;
        unique case (1'b1)
            (row_pat == 4'b1110): r = 2'd0;
            (row_pat == 4'b1101): r = 2'd1;
            (row_pat == 4'b1011): r = 2'd2;
            (row_pat == 4'b0111): r = 2'd3;
            default: valid = 1'b0;
        endcase
        code = valid ? key_lookup(r, col_idx) : 4'h0;
    end

endmodule

// File: rtl/hex_keypad_entry.sv
// Scans a 4x4 hex keypad, debounces presses and shifts accepted
// digits into a 32-bit entry register, newest digit in data[3:0].
module hex_keypad_entry #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 8
) (
    input  logic        clk,
    input  logic        rs,
    input  logic [3:0]  row,
    input  logic        clr,
    output logic [3:0]  col,
    output logic [31:0] data,
    output logic [3:0]  key_code,
    output logic        key_valid
);
    import keypad_pkg::*;

    localparam int TW = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE);

    logic [3:0]    row_m, row_s;
    logic [TW-1:0] tcnt;
    logic          tick;
    logic [1:0]    state, state_n;
    logic [7:0]    cnt, cnt_n, cnt_inc;
    logic [1:0]    cidx, cidx_n;
    logic [3:0]    pat, pat_n;
    logic          accept;
    logic          dec_valid;
    logic [3:0]    dec_code;
    logic          match, idle;

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            row_m <= 4'hF;
            row_s <= 4'hF;
            tcnt  <= '0;
        end else begin
            row_m <= row;
            row_s <= row_m;
            tcnt  <= tick ? '0 : tcnt + TW'(1);
        end
    end

    assign tick    = (tcnt == TICK_LAST);
    assign cnt_inc = cnt + 8'd1;
    assign match   = (row_s == pat);
    assign idle    = (row_s == 4'hF);

    keypad_decode u_decode (
        .col_idx (cidx),
        .row_pat (row_s),
        .valid   (dec_valid),
        .code    (dec_code)
    );

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            state <= keypad_pkg::SCAN;
            cnt   <= 8'd0;
            cidx  <= 2'd0;
            pat   <= 4'hF;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cidx  <= cidx_n;
            pat   <= pat_n;
        end
    end

    always_comb begin
        state_n = state;
        if (tick) begin
            case (state)
                keypad_pkg::SCAN:
                    if (dec_valid)
                        state_n = (DEBOUNCE == 1) ? keypad_pkg::HELD
                                                  : keypad_pkg::DEBOUNCE;
                keypad_pkg::DEBOUNCE:
                    if (!match)
                        state_n = keypad_pkg::SCAN;
                    else if (cnt_inc == DB_LAST)
                        state_n = keypad_pkg::HELD;
                keypad_pkg::HELD:
                    if (idle && cnt_inc == DB_LAST)
                        state_n = keypad_pkg::SCAN;
                default: state_n = keypad_pkg::SCAN;
            endcase
        end
    end

    always_comb begin
        cnt_n  = cnt;
        cidx_n = cidx;
        pat_n  = pat;
        accept = 1'b0;
        if (tick) begin
            case (state)
                keypad_pkg::SCAN: begin
                    if (dec_valid) begin
                        pat_n  = row_s;
                        accept = (DEBOUNCE == 1);
                        cnt_n  = (DEBOUNCE == 1) ? 8'd0 : 8'd1;
                    end else begin
                        cidx_n = cidx + 2'd1;
                    end
                end
                keypad_pkg::DEBOUNCE: begin
                    if (!match) begin
                        cnt_n  = 8'd0;
                        cidx_n = cidx + 2'd1;
                    end else if (cnt_inc == DB_LAST) begin
                        cnt_n  = 8'd0;
                        accept = 1'b1;
                    end else begin
                        cnt_n  = cnt_inc;
                    end
                end
                keypad_pkg::HELD: begin
                    // Any low row restarts the release count; no auto-repeat.
                    if (!idle) begin
                        cnt_n  = 8'd0;
                    end else if (cnt_inc == DB_LAST) begin
                        cnt_n  = 8'd0;
                        cidx_n = cidx + 2'd1;
                    end else begin
                        cnt_n  = cnt_inc;
                    end
                end
                default: cnt_n = 8'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            col       <= COL0;
            data      <= 32'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            col       <= col_drive(cidx_n);
            key_valid <= accept;
            if (accept) begin
                key_code <= dec_code;
                data     <= clr ? {28'd0, dec_code}
                                : {data[27:0], dec_code};
            end else if (clr) begin
                data <= 32'd0;
            end
        end
    end

endmodule
